// File: rtl/axi_burst_master.sv
// Command-driven AXI4 burst master.
// Each accepted command issues exactly one INCR burst: a write of the
// pattern seed+k, or a read whose beats are checked against that pattern.
// Only one transaction is in flight; completion is reported with a
// one-cycle done pulse and status.
//
// Handshake rule for every channel (cmd, AW, W, B, AR, R): a transfer
// happens on a rising clk edge where VALID and READY are both 1. A VALID
// source never drops VALID or changes payload before that edge, and READY
// may be driven without waiting for VALID.
module axi_burst_master #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // command interface
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_W-1:0]     cmd_seed,
  // completion status
  output logic                  done,
  output logic                  done_err,
  output logic [1:0]            done_resp,
  output logic [8:0]            done_mism,
  // FSM state for observation
  output logic [2:0]            dbg_state,
  // write address channel
  output logic                  M_AXI_AWVALID,
  output logic [ID_W-1:0]       M_AXI_AWID,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  input  logic                  M_AXI_AWREADY,
  // write data channel
  output logic                  M_AXI_WVALID,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  input  logic                  M_AXI_WREADY,
  // write response channel
  input  logic                  M_AXI_BVALID,
  input  logic [ID_W-1:0]       M_AXI_BID,
  input  logic [1:0]            M_AXI_BRESP,
  output logic                  M_AXI_BREADY,
  // read address channel
  output logic                  M_AXI_ARVALID,
  output logic [ID_W-1:0]       M_AXI_ARID,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  input  logic                  M_AXI_ARREADY,
  // read data channel
  input  logic                  M_AXI_RVALID,
  input  logic [ID_W-1:0]       M_AXI_RID,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_write;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [DATA_W-1:0]   r_seed;
  logic [7:0]          r_beat;
  logic                r_err;
  logic [1:0]          r_resp;
  logic [8:0]          r_mism;
  logic                r_drain;

  logic [DATA_W-1:0]   w_pattern;
  logic                w_last_beat;

  // Expected data for the current beat; same value drives WDATA and checks RDATA.
  assign w_pattern   = r_seed + DATA_W'(r_beat);
  assign w_last_beat = (r_beat == r_len);

  // Burst payload comes straight from the latched command so it stays stable.
  assign M_AXI_AWID    = r_id;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = r_len;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_ARID    = r_id;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = r_len;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_WDATA   = w_pattern;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = w_last_beat;
  assign dbg_state     = r_state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: each address/response phase exits on its handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = cmd_write ? S_AW : S_AR;
      S_AW:   if (M_AXI_AWREADY) w_next = S_W;
      S_W:    if (M_AXI_WREADY && w_last_beat) w_next = S_B;
      S_B:    if (M_AXI_BVALID) w_next = S_DONE;
      S_AR:   if (M_AXI_ARREADY) w_next = S_R;
      S_R:    if (M_AXI_RVALID && M_AXI_RLAST) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; status is only presented during DONE.
  always_comb begin
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    done          = 1'b0;
    done_err      = 1'b0;
    done_resp     = 2'b00;
    done_mism     = 9'd0;
    case (r_state)
      S_IDLE: cmd_ready     = reset;
      S_AW:   M_AXI_AWVALID = 1'b1;
      S_W:    M_AXI_WVALID  = 1'b1;
      S_B:    M_AXI_BREADY  = 1'b1;
      S_AR:   M_AXI_ARVALID = 1'b1;
      S_R:    M_AXI_RREADY  = 1'b1;
      S_DONE: begin
        done      = 1'b1;
        done_err  = r_err;
        done_resp = r_resp;
        done_mism = r_mism;
      end
      default: ;
    endcase
  end

  // Command latch, beat counter and error/mismatch accumulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_seed  <= '0;
      r_beat  <= 8'd0;
      r_err   <= 1'b0;
      r_resp  <= 2'b00;
      r_mism  <= 9'd0;
      r_drain <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_write <= cmd_write;
            r_id    <= cmd_id;
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_seed  <= cmd_seed;
            r_beat  <= 8'd0;
            r_err   <= 1'b0;
            r_resp  <= 2'b00;
            r_mism  <= 9'd0;
            r_drain <= 1'b0;
          end
        end
        // The counter wraps only on the final beat, when the FSM leaves W.
        S_W: begin
          if (M_AXI_WREADY) r_beat <= r_beat + 8'd1;
        end
        S_B: begin
          if (M_AXI_BVALID) begin
            r_resp <= M_AXI_BRESP;
            if ((M_AXI_BID != r_id) || (M_AXI_BRESP != 2'b00)) r_err <= 1'b1;
          end
        end
        // Once the expected beat count is exhausted without RLAST, remaining
        // beats are drained without data, ID or response checks.
        S_R: begin
          if (M_AXI_RVALID && !r_drain) begin
            if (M_AXI_RDATA != w_pattern) r_mism <= r_mism + 9'd1;
            if (M_AXI_RRESP != 2'b00) begin
              r_err <= 1'b1;
              if (r_resp == 2'b00) r_resp <= M_AXI_RRESP;
            end
            if (M_AXI_RID != r_id) r_err <= 1'b1;
            if (M_AXI_RLAST) begin
              if (!w_last_beat) r_err <= 1'b1;
            end else if (w_last_beat) begin
              r_err   <= 1'b1;
              r_drain <= 1'b1;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a table of burst commands with
// hand-computed status, a cycle-stepped slave, and hand sequences for
// mid-burst reset and back-to-back commands.
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_id = '0;
  logic [5:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] cmd_seed = '0;
  logic        done, done_err;
  logic [1:0]  done_resp;
  logic [8:0]  done_mism;
  logic [2:0]  dbg_state;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [5:0]  M_AXI_AWID, M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_WVALID, M_AXI_WLAST, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [5:0]  M_AXI_BID;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [5:0]  M_AXI_ARID, M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;
  logic [5:0]  M_AXI_RID;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  axi_burst_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .done(done), .done_err(done_err), .done_resp(done_resp), .done_mism(done_mism),
    .dbg_state(dbg_state),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct {
    bit          wr;
    logic [5:0]  id;
    logic [5:0]  addr;
    logic [7:0]  len;
    logic [31:0] seed;
    logic [31:0] sl_seed;   // base of data the slave returns on reads
    bit          stall;     // toggle WREADY / RVALID every cycle
    int          aw_wait;   // cycles AWREADY/ARREADY is held low
    logic [1:0]  resp;      // BRESP, or RRESP on read beat 0
    bit          id_bad;    // slave answers with the wrong ID
    int          rlast_at;  // read beat index carrying RLAST
    bit          exp_err;
    logic [1:0]  exp_resp;
    logic [8:0]  exp_mism;
    int          exp_lat;   // cmd accept to done, 0 = not checked
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  vec_t        tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // driver tasks
  task automatic slave_idle();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
    M_AXI_BVALID = 1'b0; M_AXI_BID = '0; M_AXI_BRESP = 2'b00;
    M_AXI_RVALID = 1'b0; M_AXI_RID = '0; M_AXI_RDATA = '0;
    M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0;
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_write = v.wr; cmd_id = v.id; cmd_addr = v.addr;
    cmd_len = v.len; cmd_seed = v.seed;
  endtask

  // Issue v (unless already pending), act as slave until done, check status.
  // With hold, cmd_valid stays high carrying nxt while v is in progress.
  task automatic run_vec(input vec_t v, input bit pre_issued, input bit hold, input vec_t nxt);
    int beats, rbeat, aw_cnt;
    bit aw_done, w_done, b_done, ar_done, r_done, got_done, stalled, bad_chan, w_early;
    logic [31:0] held, e;
    beats = 0; rbeat = 0; aw_cnt = 0; held = '0;
    aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
    got_done = 0; stalled = 0; bad_chan = 0; w_early = 0;
    exp_q.delete();
    if (v.wr) for (int k = 0; k <= int'(v.len); k++) exp_q.push_back(v.seed + 32'(k));
    if (!pre_issued) begin
      @(negedge clk);
      check("cmd_ready_idle", cmd_ready, 1);
      drive_cmd(v);
      cmd_valid = 1'b1;
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= 2000 && !got_done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (hold) drive_cmd(nxt);
        else cmd_valid = 1'b0;
      end
      // slave inputs for this cycle, from progress seen in earlier cycles
      M_AXI_AWREADY = (aw_cnt >= v.aw_wait);
      M_AXI_ARREADY = (aw_cnt >= v.aw_wait);
      M_AXI_WREADY  = v.stall ? (cyc % 2 == 1) : 1'b1;
      M_AXI_BVALID  = w_done && !b_done;
      M_AXI_BID     = v.id_bad ? (v.id ^ 6'h1) : v.id;
      M_AXI_BRESP   = v.resp;
      M_AXI_RVALID  = ar_done && !r_done && (!v.stall || (cyc % 2 == 1));
      M_AXI_RID     = v.id_bad ? (v.id ^ 6'h1) : v.id;
      M_AXI_RDATA   = v.sl_seed + 32'(rbeat);
      M_AXI_RRESP   = (rbeat == 0) ? v.resp : 2'b00;
      M_AXI_RLAST   = (rbeat == v.rlast_at);
      // observe DUT outputs
      check("cmd_ready_busy", cmd_ready, 0);
      if (v.wr ? (M_AXI_ARVALID || M_AXI_RREADY) : (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY))
        bad_chan = 1;
      if (M_AXI_WVALID) begin
        if (!aw_done) w_early = 1;
        if (stalled) check("wdata_stable", M_AXI_WDATA, held);
        if (M_AXI_WREADY) begin
          if (exp_q.size() == 0) check("w_extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("wdata", M_AXI_WDATA, e);
          end
          check("wlast", M_AXI_WLAST, (beats == int'(v.len)));
          check("wstrb", M_AXI_WSTRB, 4'hF);
          if (M_AXI_WLAST) w_done = 1;
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = M_AXI_WDATA;
        end
      end
      if (v.wr && M_AXI_AWVALID && !aw_done) begin
        check("awid", M_AXI_AWID, v.id);
        check("awaddr", M_AXI_AWADDR, v.addr);
        check("awlen", M_AXI_AWLEN, v.len);
        check("awsize", M_AXI_AWSIZE, 3'b010);
        check("awburst", M_AXI_AWBURST, 2'b01);
        if (M_AXI_AWREADY) aw_done = 1; else aw_cnt++;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) b_done = 1;
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        if (M_AXI_RLAST) r_done = 1;
        rbeat++;
      end
      if (!v.wr && M_AXI_ARVALID && !ar_done) begin
        check("arid", M_AXI_ARID, v.id);
        check("araddr", M_AXI_ARADDR, v.addr);
        check("arlen", M_AXI_ARLEN, v.len);
        check("arsize", M_AXI_ARSIZE, 3'b010);
        check("arburst", M_AXI_ARBURST, 2'b01);
        if (M_AXI_ARREADY) ar_done = 1; else aw_cnt++;
      end
      if (done) begin
        got_done = 1;
        check("done_err", done_err, v.exp_err);
        check("done_resp", done_resp, v.exp_resp);
        check("done_mism", done_mism, v.exp_mism);
        check("chan_order", bad_chan | w_early, 0);
        if (v.wr) begin
          check("b_seen", b_done, 1);
          check("w_beats", beats, int'(v.len) + 1);
        end else begin
          check("r_seen", r_done, 1);
        end
        if (v.exp_lat != 0) check("latency", cyc, v.exp_lat);
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    slave_idle();
    @(negedge clk);
    check("done_pulse", done, 0);
    check("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    int cnt;
    bit found;
    // wr id addr len seed sl_seed stall aw_wait resp id_bad rlast_at | err resp mism lat
    tbl[0]  = '{1, 6'd3,  6'd0,    8'd3,   32'h100,      32'h0,        0, 0, 2'd0, 0, 3,   1'b0, 2'd0, 9'd0, 0};
    tbl[1]  = '{0, 6'd3,  6'd0,    8'd3,   32'h100,      32'h100,      0, 0, 2'd0, 0, 3,   1'b0, 2'd0, 9'd0, 0};
    tbl[2]  = '{0, 6'd3,  6'd0,    8'd3,   32'h200,      32'h100,      0, 0, 2'd0, 0, 3,   1'b0, 2'd0, 9'd4, 0};
    tbl[3]  = '{1, 6'd5,  6'h10,   8'd0,   32'hABC,      32'h0,        0, 0, 2'd0, 0, 0,   1'b0, 2'd0, 9'd0, 4};
    tbl[4]  = '{0, 6'd5,  6'h10,   8'd0,   32'hABC,      32'hABC,      0, 0, 2'd0, 0, 0,   1'b0, 2'd0, 9'd0, 3};
    tbl[5]  = '{1, 6'd7,  6'h3F,   8'd255, 32'h1000,     32'h0,        1, 0, 2'd0, 0, 255, 1'b0, 2'd0, 9'd0, 0};
    tbl[6]  = '{1, 6'd2,  6'd4,    8'd1,   32'h20,       32'h0,        0, 0, 2'd2, 0, 1,   1'b1, 2'd2, 9'd0, 0};
    tbl[7]  = '{1, 6'd2,  6'd4,    8'd1,   32'h20,       32'h0,        0, 0, 2'd0, 1, 1,   1'b1, 2'd0, 9'd0, 0};
    tbl[8]  = '{0, 6'd9,  6'd8,    8'd2,   32'h30,       32'h30,       0, 0, 2'd2, 0, 2,   1'b1, 2'd2, 9'd0, 0};
    tbl[9]  = '{0, 6'd9,  6'd8,    8'd2,   32'h30,       32'h30,       0, 0, 2'd0, 1, 2,   1'b1, 2'd0, 9'd0, 0};
    tbl[10] = '{0, 6'd1,  6'd0,    8'd3,   32'h40,       32'h40,       0, 0, 2'd0, 0, 1,   1'b1, 2'd0, 9'd0, 0};
    tbl[11] = '{0, 6'd1,  6'd0,    8'd1,   32'h40,       32'h50,       0, 0, 2'd0, 0, 3,   1'b1, 2'd0, 9'd2, 0};
    tbl[12] = '{1, 6'h2A, 6'h15,   8'd2,   32'h77,       32'h0,        0, 3, 2'd0, 0, 2,   1'b0, 2'd0, 9'd0, 0};
    tbl[13] = '{0, 6'h2A, 6'h15,   8'd7,   32'h500,      32'h500,      1, 2, 2'd0, 0, 7,   1'b0, 2'd0, 9'd0, 0};
    tbl[14] = '{1, 6'd4,  6'd0,    8'd1,   32'hFFFFFFFF, 32'h0,        1, 0, 2'd0, 0, 1,   1'b0, 2'd0, 9'd0, 0};
    tbl[15] = '{0, 6'd4,  6'd0,    8'd1,   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2'd0, 0, 1,   1'b0, 2'd0, 9'd0, 0};

    slave_idle();
    // reset state
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, 3'd0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", M_AXI_AWVALID, 0);
    check("rst_wvalid", M_AXI_WVALID, 0);
    check("rst_bready", M_AXI_BREADY, 0);
    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_rready", M_AXI_RREADY, 0);
    check("rst_done", {done, done_err, done_resp, done_mism}, 0);
    reset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 16; i++) run_vec(tbl[i], 1'b0, 1'b0, tbl[i]);

    // a stray BVALID/RVALID in IDLE is not accepted
    @(negedge clk);
    M_AXI_BVALID = 1'b1; M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1;
    check("idle_bready", M_AXI_BREADY, 0);
    check("idle_rready", M_AXI_RREADY, 0);
    @(negedge clk);
    check("idle_stray_no_done", done, 0);
    slave_idle();

    // reset asserted while beat 2 of an 8-beat write is on the bus
    @(negedge clk);
    drive_cmd('{1, 6'd6, 6'd8, 8'd7, 32'h300, 32'h0, 0, 0, 2'd0, 0, 7, 1'b0, 2'd0, 9'd0, 0});
    cmd_valid = 1'b1;
    @(posedge clk);
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    cnt = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (M_AXI_WVALID) begin
        if (cnt == 2) found = 1;
        else cnt++;
      end
    end
    check("rst_mid_reached", found, 1);
    check("rst_mid_wdata_before", M_AXI_WDATA, 32'h302);
    reset = 1'b0;
    #1;
    check("rst_mid_awvalid", M_AXI_AWVALID, 0);
    check("rst_mid_wvalid", M_AXI_WVALID, 0);
    check("rst_mid_bready", M_AXI_BREADY, 0);
    check("rst_mid_state", dbg_state, 3'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_no_done", done, 0);
    end
    slave_idle();
    reset = 1'b1;
    run_vec(tbl[0], 1'b0, 1'b0, tbl[0]);
    run_vec(tbl[1], 1'b0, 1'b0, tbl[1]);

    // second command held on the bus while the first burst runs
    run_vec(tbl[3], 1'b0, 1'b1, tbl[4]);
    run_vec(tbl[4], 1'b1, 1'b0, tbl[4]);
    run_vec(tbl[0], 1'b0, 1'b1, tbl[2]);
    run_vec(tbl[2], 1'b1, 1'b0, tbl[2]);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
